// File: rtl/full_adder_4bit_bh_pkg.sv
// Shared constants for the ripple-carry adder: default operand width and
// the value the registered outputs take while reset is asserted.
package full_adder_4bit_bh_pkg;

  localparam int   WIDTH_DEF = 4;
  localparam logic RST_BIT   = 1'b0;

endpackage

// File: rtl/full_adder_1bit.sv
// One full-adder cell; the top chains WIDTH of these into a ripple adder.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ cin;
  assign cout   = (a & b) | (w_prop & cin);

endmodule

// File: rtl/full_adder_4bit_bh.sv
// Ripple-carry adder with a combinational sum/carry and a one-cycle
// registered copy carrying signed-overflow and zero flags.
module full_adder_4bit_bh
  import full_adder_4bit_bh_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q
);

  logic [WIDTH:0]   w_carry;
  logic             w_ovf;
  logic             w_zero;
  logic [WIDTH-1:0] r_sumQ;
  logic             r_coutQ;
  logic             r_ovfQ;
  logic             r_zeroQ;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1bit u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .s    (s[i]),
      .cout (w_carry[i+1])
    );
  end

  assign cout = w_carry[WIDTH];

  // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
  assign w_ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
  assign w_zero = (s == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sumQ  <= {WIDTH{RST_BIT}};
      r_coutQ <= RST_BIT;
      r_ovfQ  <= RST_BIT;
      r_zeroQ <= RST_BIT;
    end else begin
      r_sumQ  <= s;
      r_coutQ <= cout;
      r_ovfQ  <= w_ovf;
      r_zeroQ <= w_zero;
    end
  end

  assign s_q    = r_sumQ;
  assign cout_q = r_coutQ;
  assign ovf_q  = r_ovfQ;
  assign zero_q = r_zeroQ;

endmodule

// File: tb/tb_full_adder_4bit_bh.sv
// Directed and exhaustive checks of the combinational sum and the
// registered sum/flags of full_adder_4bit_bh at WIDTH=4.
module tb_full_adder_4bit_bh;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic [3:0] s_q;
  logic       cout_q;
  logic       ovf_q;
  logic       zero_q;

  int errorCount;
  int checkCount;

  full_adder_4bit_bh #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .s_q    (s_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives new operands just after a falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic [3:0] aIn, input logic [3:0] bIn, input logic cIn);
    @(negedge clk);
    a   = aIn;
    b   = bIn;
    cin = cIn;
    #1;
  endtask

  task automatic checkRegs(input string tag, input logic [3:0] sExp, input logic cExp,
                           input logic oExp, input logic zExp);
    checkOutput({tag, ".s_q"},    {4'b0, s_q},    {4'b0, sExp});
    checkOutput({tag, ".cout_q"}, {7'b0, cout_q}, {7'b0, cExp});
    checkOutput({tag, ".ovf_q"},  {7'b0, ovf_q},  {7'b0, oExp});
    checkOutput({tag, ".zero_q"}, {7'b0, zero_q}, {7'b0, zExp});
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b1;
    a   = 4'd0;
    b   = 4'd0;
    cin = 1'b0;

    @(posedge clk);
    #1;
    checkRegs("reset", 4'h0, 1'b0, 1'b0, 1'b0);

    rst = 1'b0;

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a   = 4'(ia);
          b   = 4'(ib);
          cin = 1'(ic);
          #1;
          checkOutput("exhaustive", {3'b0, cout, s}, 8'(ia + ib + ic));
          #9;
        end
      end
    end

    applyStimulus(4'b1111, 4'b0001, 1'b0);
    checkOutput("F+1.comb", {3'b0, cout, s}, 8'h10);
    @(posedge clk); #1;
    checkRegs("F+1", 4'b0000, 1'b1, 1'b0, 1'b1);

    applyStimulus(4'b0111, 4'b0001, 1'b0);
    checkOutput("7+1.comb", {3'b0, cout, s}, 8'h08);
    @(posedge clk); #1;
    checkRegs("7+1", 4'b1000, 1'b0, 1'b1, 1'b0);

    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkOutput("F+F+1.comb", {3'b0, cout, s}, 8'h1F);
    @(posedge clk); #1;
    checkRegs("F+F+1", 4'b1111, 1'b1, 1'b0, 1'b0);

    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("F+0+1.comb", {3'b0, cout, s}, 8'h10);
    @(posedge clk); #1;
    checkRegs("F+0+1", 4'b0000, 1'b1, 1'b0, 1'b1);

    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("0+0+0.comb", {3'b0, cout, s}, 8'h00);
    @(posedge clk); #1;
    checkRegs("0+0+0", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Reset while operands are live: registers clear, combinational path keeps tracking.
    applyStimulus(4'd5, 4'd6, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkRegs("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.comb", {3'b0, cout, s}, 8'h0B);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkRegs("after_rst", 4'b1011, 1'b0, 1'b1, 1'b0);

    applyStimulus(4'd2, 4'd3, 1'b0);
    checkOutput("midcycle.s", {4'b0, s}, 8'h05);
    checkOutput("midcycle.s_q", {4'b0, s_q}, 8'h0B);
    @(posedge clk); #1;
    checkRegs("midcycle_edge", 4'b0101, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
